imem_sync: RTL and testbench

- Parametrised synchronous instruction memory for the RISC-V pipeline fetch stage; successor to the combinational hard-coded ROM.
- Adds a valid/ready fetch handshake, a configurable wait-state count and a programming write port so benches and boot logic can load code.
- Adds fault reporting for misaligned and out-of-range fetches.
- Sits between the IF stage (requester) and the program-load path / testbench.

---
 rtl/imem_sync.sv | 148 ++++++++++++++
 tb/tb_imem_sync.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_sync.sv
// Synchronous instruction memory for the fetch stage: valid/ready fetch
// handshake, configurable wait states, programming port, fault reporting.
module imem_sync #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    output logic              prog_err
);

    localparam int unsigned IDX_W   = ADDR_W - 2;
    localparam int unsigned MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0]  WAIT_CNT  = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_fault_q;
    logic               prog_err_q;
    logic               accept;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   prog_idx;
    logic               req_bad;
    logic               prog_bad;

    // Address decode and fault classification for both ports
    always_comb begin
        req_idx  = req_addr[ADDR_W-1:2];
        prog_idx = prog_addr[ADDR_W-1:2];
        req_bad  = (req_addr[1:0] != 2'b00) || ({2'b00, req_idx} >= DEPTH_LIM);
        prog_bad = (prog_addr[1:0] != 2'b00) || ({2'b00, prog_idx} >= DEPTH_LIM);
    end

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; an accept always restarts the IDLE sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_CNT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (accept) begin
                        if (WAIT_CYCLES == 0) begin
                            state_d = S_RESP;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = WAIT_CNT;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake outputs; ready only looks at state and rsp_ready
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        if (!reset) begin
            req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
        end
        rsp_valid = (state_q == S_RESP);
        accept    = req_valid && req_ready;
    end

    // Response capture at accept (read-before-write) and program error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
            prog_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                rsp_fault_q <= req_bad;
                rsp_data_q  <= req_bad ? '0 : mem[req_idx[MEM_AW-1:0]];
            end
            prog_err_q <= prog_we && prog_bad;
        end
    end

    // Programming write port; contents are not touched by reset
    always_ff @(posedge clk) begin
        if (!reset && prog_we && !prog_bad) begin
            mem[prog_idx[MEM_AW-1:0]] <= prog_wdata;
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;
    assign prog_err  = prog_err_q;

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync: four instances cover WAIT_CYCLES 0/3/2 and DEPTH 23.
module tb_imem_sync;

    logic        clk;
    logic        reset;
    logic        req_valid  [4];
    logic        req_ready  [4];
    logic [31:0] req_addr   [4];
    logic        rsp_valid  [4];
    logic        rsp_ready  [4];
    logic [31:0] rsp_data   [4];
    logic        rsp_fault  [4];
    logic        prog_we    [4];
    logic [31:0] prog_addr  [4];
    logic [31:0] prog_wdata [4];
    logic        prog_err   [4];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    imem_sync #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_fault(rsp_fault[0]), .prog_we(prog_we[0]), .prog_addr(prog_addr[0]),
        .prog_wdata(prog_wdata[0]), .prog_err(prog_err[0]));

    imem_sync #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_fault(rsp_fault[1]), .prog_we(prog_we[1]), .prog_addr(prog_addr[1]),
        .prog_wdata(prog_wdata[1]), .prog_err(prog_err[1]));

    imem_sync #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data[2]),
        .rsp_fault(rsp_fault[2]), .prog_we(prog_we[2]), .prog_addr(prog_addr[2]),
        .prog_wdata(prog_wdata[2]), .prog_err(prog_err[2]));

    imem_sync #(.DATA_W(32), .DEPTH(23), .ADDR_W(32), .WAIT_CYCLES(0)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[3]), .req_ready(req_ready[3]), .req_addr(req_addr[3]),
        .rsp_valid(rsp_valid[3]), .rsp_ready(rsp_ready[3]), .rsp_data(rsp_data[3]),
        .rsp_fault(rsp_fault[3]), .prog_we(prog_we[3]), .prog_addr(prog_addr[3]),
        .prog_wdata(prog_wdata[3]), .prog_err(prog_err[3]));

    typedef struct {
        int          dut;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge one cycle after the write
    task automatic prog(input int d, input logic [31:0] a, input logic [31:0] v,
                        input logic exp_err);
        prog_we[d] = 1'b1; prog_addr[d] = a; prog_wdata[d] = v;
        @(negedge clk);
        prog_we[d] = 1'b0;
        check($sformatf("prog_err d%0d @%h", d, a), 32'(prog_err[d]), 32'(exp_err));
    endtask

    // Called at a negedge; returns at the negedge where the response is visible
    task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] ed,
                         input logic ef, input int el);
        int n;
        req_addr[d] = a; req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
        n = 0;
        #1;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check($sformatf("accept d%0d @%h", d, a), 32'(n < 20), 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 1;
        while (!rsp_valid[d] && n < 40) begin
            @(negedge clk); n++;
        end
        check($sformatf("latency d%0d @%h", d, a), 32'(n), 32'(el));
        check($sformatf("data d%0d @%h", d, a), rsp_data[d], ed);
        check($sformatf("fault d%0d @%h", d, a), 32'(rsp_fault[d]), 32'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b0;
            prog_we[i] = 1'b0; prog_addr[i] = '0; prog_wdata[i] = '0;
        end

        vecs[0] = '{0, 32'h0000_0000, 32'hE04F_000F, 1'b0};
        vecs[1] = '{0, 32'h0000_0004, 32'hE280_2005, 1'b0};
        vecs[2] = '{0, 32'h0000_0020, 32'h0A00_000C, 1'b0};
        vecs[3] = '{0, 32'h0000_00FC, 32'h1357_9BDF, 1'b0};
        vecs[4] = '{0, 32'h0000_0006, 32'h0000_0000, 1'b1};
        vecs[5] = '{0, 32'h0000_0100, 32'h0000_0000, 1'b1};
        vecs[6] = '{3, 32'h0000_0058, 32'hCAFE_F00D, 1'b0};
        vecs[7] = '{3, 32'h0000_0000, 32'h1111_1111, 1'b0};
        vecs[8] = '{3, 32'h0000_005C, 32'h0000_0000, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready[0]), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset rsp_data", rsp_data[0], 32'd0);
        check("reset rsp_fault", 32'(rsp_fault[0]), 32'd0);
        check("reset prog_err", 32'(prog_err[0]), 32'd0);
        reset = 1'b0;
        #1;
        check("post-reset req_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);

        // Program all good words from the table
        for (int i = 0; i < 9; i++) begin
            if (!vecs[i].fault) prog(vecs[i].dut, vecs[i].addr, vecs[i].data, 1'b0);
        end

        // Table fetches, zero wait states
        for (int i = 0; i < 9; i++) begin
            fetch(vecs[i].dut, vecs[i].addr, vecs[i].data, vecs[i].fault, 1);
        end
        @(negedge clk);

        // Back-to-back fetches 0x0, 0x4, 0x20 with no bubble
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_addr[0] = 32'h0;
        #1;
        check("b2b ready0", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        check("b2b valid0", 32'(rsp_valid[0]), 32'd1);
        check("b2b data0", rsp_data[0], 32'hE04F_000F);
        req_addr[0] = 32'h4;
        @(negedge clk);
        check("b2b valid1", 32'(rsp_valid[0]), 32'd1);
        check("b2b data1", rsp_data[0], 32'hE280_2005);
        req_addr[0] = 32'h20;
        @(negedge clk);
        check("b2b valid2", 32'(rsp_valid[0]), 32'd1);
        check("b2b data2", rsp_data[0], 32'h0A00_000C);
        check("b2b fault2", 32'(rsp_fault[0]), 32'd0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("b2b idle", 32'(rsp_valid[0]), 32'd0);

        // Dropped write: prog_err is a single pulse and memory is untouched
        prog(0, 32'h0000_0101, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("prog_err single pulse", 32'(prog_err[0]), 32'd0);
        fetch(0, 32'h0, 32'hE04F_000F, 1'b0, 1);
        fetch(0, 32'h100, 32'h0, 1'b1, 1);
        prog(3, 32'h0000_005C, 32'h5555_AAAA, 1'b1);

        // Read-before-write on the same word
        prog(0, 32'h8, 32'hE243_7009, 1'b0);
        req_valid[0] = 1'b1; req_addr[0] = 32'h8; rsp_ready[0] = 1'b1;
        prog_we[0] = 1'b1; prog_addr[0] = 32'h8; prog_wdata[0] = 32'hAA00_0000;
        @(negedge clk);
        req_valid[0] = 1'b0; prog_we[0] = 1'b0;
        check("rbw valid", 32'(rsp_valid[0]), 32'd1);
        check("rbw old data", rsp_data[0], 32'hE243_7009);
        fetch(0, 32'h8, 32'hAA00_0000, 1'b0, 1);
        @(negedge clk);

        // Wait states with backpressure
        prog(1, 32'h4, 32'hE280_2005, 1'b0);
        req_valid[1] = 1'b1; req_addr[1] = 32'h4; rsp_ready[1] = 1'b0;
        #1;
        check("ws accept ready", 32'(req_ready[1]), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_valid[1] = 1'b0;
            check($sformatf("ws wait valid c%0d", c), 32'(rsp_valid[1]), 32'd0);
            check($sformatf("ws wait ready c%0d", c), 32'(req_ready[1]), 32'd0);
        end
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("ws hold valid c%0d", c), 32'(rsp_valid[1]), 32'd1);
            check($sformatf("ws hold data c%0d", c), rsp_data[1], 32'hE280_2005);
            check($sformatf("ws hold ready c%0d", c), 32'(req_ready[1]), 32'd0);
        end
        rsp_ready[1] = 1'b1;
        #1;
        check("ws consume ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        check("ws after consume", 32'(rsp_valid[1]), 32'd0);

        // Reset while a request sits in WAIT
        prog(2, 32'h10, 32'h1234_5678, 1'b0);
        req_valid[2] = 1'b1; req_addr[2] = 32'h10; rsp_ready[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("rst mid wait", 32'(rsp_valid[2]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst valid", 32'(rsp_valid[2]), 32'd0);
        check("rst ready", 32'(req_ready[2]), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rst no stale c%0d", c), 32'(rsp_valid[2]), 32'd0);
        end
        fetch(2, 32'h10, 32'h1234_5678, 1'b0, 3);
        fetch(0, 32'h20, 32'h0A00_000C, 1'b0, 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
